// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
// Issues loads/stores on the data bus, aligns store lanes, extends load data,
// stalls the front of the pipe while the bus is busy and registers MEM/WB.
// Optional feature macro: MEM_MISALIGN_EXC_EN (misaligned-access exception).
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_mem_opcode,
  input  logic [31:0] ex_address,
  input  logic [31:0] ex_writedata,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_reg_regid,
  input  logic [31:0] ex_reg_writedata,
  input  logic        ex_csr_read,
  input  logic        ex_csr_write,
  input  logic [1:0]  ex_csr_write_opcode,
  input  logic [11:0] ex_csr_address,
  input  logic [31:0] ex_csr_writedata,
  output logic        dbus_read,
  output logic        dbus_write,
  output logic [31:0] dbus_address,
  output logic [31:0] dbus_writedata,
  output logic [3:0]  dbus_byteenable,
  input  logic        dbus_waitrequest,
  input  logic        dbus_readdatavalid,
  input  logic [31:0] dbus_readdata,
  output logic        mem_stall,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_csr_read,
  output logic        wb_csr_write,
  output logic [4:0]  wb_reg_regid,
  output logic [31:0] wb_reg_writedata,
  output logic [1:0]  wb_csr_write_opcode,
  output logic [11:0] wb_csr_address,
  output logic [31:0] wb_csr_writedata
`ifdef MEM_MISALIGN_EXC_EN
  ,
  output logic        wb_exception,
  output logic [4:0]  wb_exception_code,
  output logic [31:0] wb_mtval
`endif
);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMD  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Byte-lane enables for an access of the given size at byte offset a.
  function automatic logic [3:0] lane_enable(input logic [2:0] op, input logic [1:0] a);
    logic [3:0] be;
    case (op)
      F3_B, F3_BU: be = 4'b0001 << a;
      F3_H, F3_HU: be = 4'b0011 << {a[1], 1'b0};
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so the enabled lanes carry it.
  function automatic logic [31:0] lane_data(input logic [2:0] op, input logic [31:0] d);
    logic [31:0] r;
    case (op)
      F3_B, F3_BU: r = {4{d[7:0]}};
      F3_H, F3_HU: r = {2{d[15:0]}};
      default:     r = d;
    endcase
    return r;
  endfunction

  // Pick the addressed byte/halfword out of the read word and extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      2'd3:    b = rd[31:24];
      default: b = rd[7:0];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (op)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = rd;
    endcase
    return r;
  endfunction

`ifdef MEM_MISALIGN_EXC_EN
  // Halfwords need a[0]=0, words need a=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] a);
    logic m;
    case (op)
      F3_H, F3_HU: m = a[0];
      F3_B, F3_BU: m = 1'b0;
      default:     m = (a != 2'd0);
    endcase
    return m;
  endfunction
`endif

  state_e      state_q, state_d;
  logic        access_s, is_load_s, mis_s, go_s;
  logic        cmd_s, stall_s;

  logic        wb_valid_q, wb_valid_d;
  logic        wb_reg_write_q, wb_reg_write_d;
  logic        wb_csr_read_q, wb_csr_read_d;
  logic        wb_csr_write_q, wb_csr_write_d;
  logic [4:0]  wb_reg_regid_q, wb_reg_regid_d;
  logic [31:0] wb_reg_writedata_q, wb_reg_writedata_d;
  logic [1:0]  wb_csr_write_opcode_q, wb_csr_write_opcode_d;
  logic [11:0] wb_csr_address_q, wb_csr_address_d;
  logic [31:0] wb_csr_writedata_q, wb_csr_writedata_d;
  logic        wb_exception_q, wb_exception_d;
  logic [4:0]  wb_exception_code_q, wb_exception_code_d;
  logic [31:0] wb_mtval_q, wb_mtval_d;

  // Classify the instruction in the EX/MEM slot; loads win if both flags set.
  always_comb begin
    access_s  = ex_valid & (ex_mem_read | ex_mem_write);
    is_load_s = ex_mem_read;
`ifdef MEM_MISALIGN_EXC_EN
    mis_s     = access_s & is_misaligned(ex_mem_opcode, ex_address[1:0]);
`else
    mis_s     = 1'b0;
`endif
    go_s      = access_s & ~mis_s;
  end

  // Bus handshake FSM: next state, command enable and stall decision.
  always_comb begin
    state_d = state_q;
    cmd_s   = 1'b0;
    stall_s = 1'b0;
    case (state_q)
      S_IDLE, S_CMD: begin
        if (go_s) begin
          cmd_s = 1'b1;
          if (dbus_waitrequest) begin
            state_d = S_CMD;
            stall_s = 1'b1;
          end else if (!is_load_s || dbus_readdatavalid) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
            stall_s = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (dbus_readdatavalid) begin
          state_d = S_IDLE;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bus command and stall outputs, forced quiet while reset is held.
  always_comb begin
    dbus_read       = ~rst & cmd_s & is_load_s;
    dbus_write      = ~rst & cmd_s & ~is_load_s;
    mem_stall       = ~rst & stall_s;
    dbus_address    = {ex_address[31:2], 2'b00};
    dbus_byteenable = lane_enable(ex_mem_opcode, ex_address[1:0]);
    dbus_writedata  = lane_data(ex_mem_opcode, ex_writedata);
  end

  // MEM/WB next values: a bubble while stalled, else the instruction itself.
  always_comb begin
    wb_valid_d            = ex_valid & ~stall_s;
    wb_reg_write_d        = ex_reg_write & ~mis_s & ~stall_s;
    wb_csr_read_d         = ex_csr_read & ~stall_s;
    wb_csr_write_d        = ex_csr_write & ~stall_s;
    wb_reg_regid_d        = ex_reg_regid;
    wb_reg_writedata_d    = (go_s & is_load_s)
                            ? load_extend(ex_mem_opcode, ex_address[1:0], dbus_readdata)
                            : ex_reg_writedata;
    wb_csr_write_opcode_d = ex_csr_write_opcode;
    wb_csr_address_d      = ex_csr_address;
    wb_csr_writedata_d    = ex_csr_writedata;
    wb_exception_d        = mis_s & ~stall_s;
    wb_exception_code_d   = mis_s ? (is_load_s ? 5'd4 : 5'd6) : 5'd0;
    wb_mtval_d            = mis_s ? ex_address : 32'd0;
  end

  // State and MEM/WB pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q               <= S_IDLE;
      wb_valid_q            <= 1'b0;
      wb_reg_write_q        <= 1'b0;
      wb_csr_read_q         <= 1'b0;
      wb_csr_write_q        <= 1'b0;
      wb_reg_regid_q        <= 5'd0;
      wb_reg_writedata_q    <= 32'd0;
      wb_csr_write_opcode_q <= 2'd0;
      wb_csr_address_q      <= 12'd0;
      wb_csr_writedata_q    <= 32'd0;
      wb_exception_q        <= 1'b0;
      wb_exception_code_q   <= 5'd0;
      wb_mtval_q            <= 32'd0;
    end else begin
      state_q               <= state_d;
      wb_valid_q            <= wb_valid_d;
      wb_reg_write_q        <= wb_reg_write_d;
      wb_csr_read_q         <= wb_csr_read_d;
      wb_csr_write_q        <= wb_csr_write_d;
      wb_reg_regid_q        <= wb_reg_regid_d;
      wb_reg_writedata_q    <= wb_reg_writedata_d;
      wb_csr_write_opcode_q <= wb_csr_write_opcode_d;
      wb_csr_address_q      <= wb_csr_address_d;
      wb_csr_writedata_q    <= wb_csr_writedata_d;
      wb_exception_q        <= wb_exception_d;
      wb_exception_code_q   <= wb_exception_code_d;
      wb_mtval_q            <= wb_mtval_d;
    end
  end

  assign wb_valid            = wb_valid_q;
  assign wb_reg_write        = wb_reg_write_q;
  assign wb_csr_read         = wb_csr_read_q;
  assign wb_csr_write        = wb_csr_write_q;
  assign wb_reg_regid        = wb_reg_regid_q;
  assign wb_reg_writedata    = wb_reg_writedata_q;
  assign wb_csr_write_opcode = wb_csr_write_opcode_q;
  assign wb_csr_address      = wb_csr_address_q;
  assign wb_csr_writedata    = wb_csr_writedata_q;
`ifdef MEM_MISALIGN_EXC_EN
  assign wb_exception        = wb_exception_q;
  assign wb_exception_code   = wb_exception_code_q;
  assign wb_mtval            = wb_mtval_q;
`else
  logic unused_exc_s;
  assign unused_exc_s = wb_exception_q ^ (^wb_exception_code_q) ^ (^wb_mtval_q);
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// loads/stores/ALU ops, checked against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_mem_opcode;
  logic [31:0] ex_address, ex_writedata;
  logic        ex_reg_write;
  logic [4:0]  ex_reg_regid;
  logic [31:0] ex_reg_writedata;
  logic        ex_csr_read, ex_csr_write;
  logic [1:0]  ex_csr_write_opcode;
  logic [11:0] ex_csr_address;
  logic [31:0] ex_csr_writedata;
  logic        dbus_read, dbus_write;
  logic [31:0] dbus_address, dbus_writedata;
  logic [3:0]  dbus_byteenable;
  logic        dbus_waitrequest, dbus_readdatavalid;
  logic [31:0] dbus_readdata;
  logic        mem_stall;
  logic        wb_valid, wb_reg_write, wb_csr_read, wb_csr_write;
  logic [4:0]  wb_reg_regid;
  logic [31:0] wb_reg_writedata;
  logic [1:0]  wb_csr_write_opcode;
  logic [11:0] wb_csr_address;
  logic [31:0] wb_csr_writedata;
`ifdef MEM_MISALIGN_EXC_EN
  logic        wb_exception;
  logic [4:0]  wb_exception_code;
  logic [31:0] wb_mtval;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_opcode(ex_mem_opcode), .ex_address(ex_address), .ex_writedata(ex_writedata),
    .ex_reg_write(ex_reg_write), .ex_reg_regid(ex_reg_regid),
    .ex_reg_writedata(ex_reg_writedata), .ex_csr_read(ex_csr_read),
    .ex_csr_write(ex_csr_write), .ex_csr_write_opcode(ex_csr_write_opcode),
    .ex_csr_address(ex_csr_address), .ex_csr_writedata(ex_csr_writedata),
    .dbus_read(dbus_read), .dbus_write(dbus_write), .dbus_address(dbus_address),
    .dbus_writedata(dbus_writedata), .dbus_byteenable(dbus_byteenable),
    .dbus_waitrequest(dbus_waitrequest), .dbus_readdatavalid(dbus_readdatavalid),
    .dbus_readdata(dbus_readdata), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_csr_read(wb_csr_read),
    .wb_csr_write(wb_csr_write), .wb_reg_regid(wb_reg_regid),
    .wb_reg_writedata(wb_reg_writedata), .wb_csr_write_opcode(wb_csr_write_opcode),
    .wb_csr_address(wb_csr_address), .wb_csr_writedata(wb_csr_writedata)
`ifdef MEM_MISALIGN_EXC_EN
    , .wb_exception(wb_exception), .wb_exception_code(wb_exception_code),
    .wb_mtval(wb_mtval)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference: lanes written by a store of size op at offset a.
  function automatic logic [3:0] ref_be(input logic [2:0] op, input logic [1:0] a);
    int n;
    if (op == 3'd0) n = 1 << int'(a);
    else if (op == 3'd1) n = 3 << (2 * (int'(a) / 2));
    else n = 15;
    return 4'(n);
  endfunction

  // Reference: store word with the datum copied into every lane.
  function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] d);
    if (op == 3'd0) return (d & 32'hFF) * 32'h01010101;
    else if (op == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
    else return d;
  endfunction

  // Reference: loaded value, two's-complement extended via subtraction.
  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                           input logic [31:0] rd);
    logic [31:0] v;
    case (op)
      3'd0, 3'd4: begin
        v = (rd >> (8 * int'(a))) & 32'hFF;
        if (op == 3'd0 && v >= 32'h80) v = v - 32'h100;
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * (int'(a) / 2))) & 32'hFFFF;
        if (op == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

`ifdef MEM_MISALIGN_EXC_EN
  function automatic logic ref_mis(input logic [2:0] op, input logic [1:0] a);
    if (op == 3'd1 || op == 3'd5) return a[0];
    else if (op == 3'd2) return a != 2'd0;
    else return 1'b0;
  endfunction
`endif

  // One instruction: w wait-request cycles, then for loads l cycles until data.
  task automatic do_txn(input logic vld, input logic ld, input logic st,
                        input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd,
                        input int w, input int l);
    logic acc, is_ld, is_st, mis;
    int last;
    @(negedge clk);
    ex_valid = vld; ex_mem_read = ld; ex_mem_write = st; ex_mem_opcode = op;
    ex_address = addr; ex_writedata = wd;
    ex_reg_write = 1'($urandom); ex_reg_regid = 5'($urandom);
    ex_reg_writedata = $urandom; ex_csr_read = 1'($urandom);
    ex_csr_write = 1'($urandom); ex_csr_write_opcode = 2'($urandom);
    ex_csr_address = 12'($urandom); ex_csr_writedata = $urandom;
    acc = vld & (ld | st);
    is_ld = acc & ld;
    is_st = acc & st & ~ld;
    mis = 1'b0;
`ifdef MEM_MISALIGN_EXC_EN
    mis = acc & ref_mis(op, addr[1:0]);
`endif
    if (!acc || mis) begin w = 0; l = 0; end
    if (is_st) l = 0;
    last = w + l;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) @(negedge clk);
      dbus_waitrequest   = (k < w);
      dbus_readdatavalid = (is_ld && !mis) ? (k == last) : (!acc && 1'($urandom));
      dbus_readdata      = (k == last) ? rd : $urandom;
      #1;
      chk1("dbus_read", dbus_read, is_ld && !mis && (k <= w));
      chk1("dbus_write", dbus_write, is_st && !mis && (k <= w));
      chk1("mem_stall", mem_stall, k != last);
      if (acc && !mis && (k <= w)) begin
        chk("dbus_address", dbus_address, addr & 32'hFFFF_FFFC);
        if (is_st) begin
          chk("dbus_byteenable", {28'd0, dbus_byteenable}, {28'd0, ref_be(op, addr[1:0])});
          chk("dbus_writedata", dbus_writedata, ref_wdata(op, wd));
        end
      end
      @(posedge clk);
      #1;
      if (k != last) begin
        chk1("bubble_valid", wb_valid, 1'b0);
        chk1("bubble_reg_write", wb_reg_write, 1'b0);
        chk1("bubble_csr_read", wb_csr_read, 1'b0);
        chk1("bubble_csr_write", wb_csr_write, 1'b0);
      end else begin
        chk1("wb_valid", wb_valid, vld);
        chk1("wb_reg_write", wb_reg_write, ex_reg_write & ~mis);
        chk1("wb_csr_read", wb_csr_read, ex_csr_read);
        chk1("wb_csr_write", wb_csr_write, ex_csr_write);
        chk("wb_reg_regid", {27'd0, wb_reg_regid}, {27'd0, ex_reg_regid});
        chk("wb_reg_writedata", wb_reg_writedata,
            (is_ld && !mis) ? ref_load(op, addr[1:0], rd) : ex_reg_writedata);
        chk("wb_csr_write_opcode", {30'd0, wb_csr_write_opcode}, {30'd0, ex_csr_write_opcode});
        chk("wb_csr_address", {20'd0, wb_csr_address}, {20'd0, ex_csr_address});
        chk("wb_csr_writedata", wb_csr_writedata, ex_csr_writedata);
`ifdef MEM_MISALIGN_EXC_EN
        chk1("wb_exception", wb_exception, mis);
        if (mis) begin
          chk("wb_exception_code", {27'd0, wb_exception_code}, is_ld ? 32'd4 : 32'd6);
          chk("wb_mtval", wb_mtval, addr);
        end
`endif
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_opcode = 3'd0;
    ex_address = 32'd0; ex_writedata = 32'd0; ex_reg_write = 1'b0; ex_reg_regid = 5'd0;
    ex_reg_writedata = 32'd0; ex_csr_read = 1'b0; ex_csr_write = 1'b0;
    ex_csr_write_opcode = 2'd0; ex_csr_address = 12'd0; ex_csr_writedata = 32'd0;
    dbus_waitrequest = 1'b0; dbus_readdatavalid = 1'b0; dbus_readdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_wb_valid", wb_valid, 1'b0);
    chk1("rst_wb_reg_write", wb_reg_write, 1'b0);
    chk("rst_wb_reg_writedata", wb_reg_writedata, 32'd0);
    chk1("rst_dbus_read", dbus_read, 1'b0);
    chk1("rst_dbus_write", dbus_write, 1'b0);
    chk1("rst_mem_stall", mem_stall, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // SW 0x104, accepted immediately
    do_txn(1'b1, 1'b0, 1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'd0, 0, 0);
    chk("sw_address", dbus_address, 32'h104);
    chk("sw_byteenable", {28'd0, dbus_byteenable}, 32'hF);
    chk1("sw_wb_valid", wb_valid, 1'b1);
    chk1("sw_wb_reg_write", wb_reg_write, 1'b0);

    // LB / LBU at 0x203, data two cycles after accept
    do_txn(1'b1, 1'b1, 1'b0, 3'd0, 32'h203, 32'd0, 32'h80123456, 0, 2);
    chk("lb_data", wb_reg_writedata, 32'hFFFFFF80);
    do_txn(1'b1, 1'b1, 1'b0, 3'd4, 32'h203, 32'd0, 32'h80123456, 0, 2);
    chk("lbu_data", wb_reg_writedata, 32'h00000080);

    // SH 0x12 with three wait-request cycles
    do_txn(1'b1, 1'b0, 1'b1, 3'd1, 32'h12, 32'h0000ABCD, 32'd0, 3, 0);
    chk("sh_byteenable", {28'd0, dbus_byteenable}, 32'hC);
    chk("sh_writedata", dbus_writedata, 32'hABCDABCD);

    // LH 0x40 with data in the accept cycle
    do_txn(1'b1, 1'b1, 1'b0, 3'd1, 32'h40, 32'd0, 32'h00007FFE, 0, 0);
    chk("lh_data", wb_reg_writedata, 32'h00007FFE);

    // Reset while waiting for a read response, then a late response
    @(negedge clk);
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_mem_opcode = 3'd2;
    ex_address = 32'h80; dbus_waitrequest = 1'b0; dbus_readdatavalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    chk1("resp_dbus_read", dbus_read, 1'b0);
    chk1("resp_mem_stall", mem_stall, 1'b1);
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
    ex_csr_read = 1'b0; ex_csr_write = 1'b0;
    @(posedge clk);
    #1;
    chk1("midrst_wb_valid", wb_valid, 1'b0);
    chk1("midrst_wb_reg_write", wb_reg_write, 1'b0);
    chk("midrst_wb_reg_writedata", wb_reg_writedata, 32'd0);
    chk("midrst_wb_csr_writedata", wb_csr_writedata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dbus_readdatavalid = 1'b1; dbus_readdata = 32'hCAFEF00D;
    #1;
    chk1("late_resp_mem_stall", mem_stall, 1'b0);
    chk1("late_resp_dbus_read", dbus_read, 1'b0);
    @(posedge clk);
    #1;
    chk1("late_resp_wb_valid", wb_valid, 1'b0);
    do_txn(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 32'd0, 32'd0, 0, 0);
    chk1("alu_after_rst_valid", wb_valid, 1'b1);

`ifdef MEM_MISALIGN_EXC_EN
    // Misaligned word load raises an exception without touching the bus
    do_txn(1'b1, 1'b1, 1'b0, 3'd2, 32'h6, 32'd0, 32'd0, 2, 2);
    chk1("mis_exception", wb_exception, 1'b1);
    chk("mis_code", {27'd0, wb_exception_code}, 32'd4);
    chk("mis_mtval", wb_mtval, 32'h6);
    chk1("mis_reg_write", wb_reg_write, 1'b0);
`endif

    // Random mix of ALU ops, loads, stores and idle slots
    for (int n = 0; n < 200; n++) begin
      int kind;
      logic [2:0] op;
      kind = int'($urandom_range(0, 3));
      case (kind)
        0: do_txn(1'b1, 1'b0, 1'b0, 3'd0, $urandom, $urandom, $urandom, 0, 0);
        1: begin
          case ($urandom_range(0, 4))
            0: op = 3'd0;
            1: op = 3'd1;
            2: op = 3'd2;
            3: op = 3'd4;
            default: op = 3'd5;
          endcase
          do_txn(1'b1, 1'b1, 1'b0, op, $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        2: begin
          op = 3'($urandom_range(0, 2));
          do_txn(1'b1, 1'b0, 1'b1, op, $urandom, $urandom, $urandom,
                 int'($urandom_range(0, 3)), 0);
        end
        default: do_txn(1'b0, 1'($urandom), 1'($urandom), 3'd2, $urandom, $urandom,
                        $urandom, 0, 0);
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the execute stage and the write-back stage.
- Issues loads and stores on the data bus, aligns store data and byte enables, and sign/zero-extends load data.
- Holds the pipeline with a stall while the bus is busy.
- Registers the MEM/WB pipeline fields that the write-back stage and CSR unit consume.

Parameters:
- none (data width fixed at 32, register id width fixed at 5)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- ex_valid  in  1  EX/MEM slot holds a live instruction
- ex_mem_read  in  1  instruction is a load
- ex_mem_write  in  1  instruction is a store
- ex_mem_opcode  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_address  in  32  byte address (ALU result)
- ex_writedata  in  32  store data (rs2)
- ex_reg_write  in  1  destination register write
- ex_reg_regid  in  5  destination register id
- ex_reg_writedata  in  32  non-load result
- ex_csr_read / ex_csr_write  in  1 each  CSR controls, passed through
- ex_csr_write_opcode  in  2  CSR op, passed through
- ex_csr_address  in  12  CSR address, passed through
- ex_csr_writedata  in  32  CSR operand, passed through
- dbus_read / dbus_write  out  1 each  bus command
- dbus_address  out  32  word-aligned address
- dbus_writedata  out  32  lane-replicated store data
- dbus_byteenable  out  4  byte lanes
- dbus_waitrequest  in  1  slave not accepting command
- dbus_readdatavalid  in  1  read response valid
- dbus_readdata  in  32  read response word
- mem_stall  out  1  hold IF/ID/EX and EX/MEM registers
- wb_valid, wb_reg_write, wb_csr_read, wb_csr_write  out  1 each  MEM/WB control
- wb_reg_regid  out  5;  wb_reg_writedata  out  32
- wb_csr_write_opcode  out  2;  wb_csr_address  out  12;  wb_csr_writedata  out  32

Behaviour:
- Clock/reset: single clock clk; reset rst is synchronous, active-high.
- Reset value of every output: all wb_* registers 0; state IDLE. All combinational outputs are therefore 0: dbus_read, dbus_write, mem_stall.
- Access = ex_valid & (ex_mem_read | ex_mem_write).
- FSM states: IDLE, CMD (command presented, waitrequest seen), RESP (read accepted, awaiting readdatavalid).
- IDLE, no access: no bus activity, mem_stall=0, wb_* load the ex_* values next edge (1-cycle latency).
- IDLE, access: dbus_read/dbus_write assert combinationally the same cycle.
  - waitrequest=1 -> go to CMD.
  - Store with waitrequest=0 -> store is done; stay IDLE.
  - Load with waitrequest=0 -> go to RESP, unless readdatavalid is also 1 that cycle (done).
- CMD: command held stable; same exits as IDLE once waitrequest=0.
- RESP: dbus_read=0; exit to IDLE on readdatavalid.
- mem_stall=1 every cycle of an access except the completion cycle.
  - Completion cycle: a store accepted, or readdatavalid seen.
- Pipeline register during stall: while mem_stall=1, the wb_* registers load a bubble (wb_valid=0, wb_reg_write=0, wb_csr_write=0, wb_csr_read=0).
- Pipeline register on completion: wb_* capture the instruction, with wb_reg_writedata = extended load data for loads.
- Address: dbus_address = {ex_address[31:2], 2'b00}; a = ex_address[1:0].
- Byte enables: B -> 4'b0001<<a; H -> 4'b0011<<{a[1],0}; W -> 4'b1111.
- Store data: B replicates byte 4x; H replicates halfword 2x; W as-is.
- Load extension: select byte a (or halfword a[1]) from dbus_readdata. B/H sign-extend, BU/HU zero-extend, W passes through.
- ex_* inputs are stable while mem_stall=1 (upstream guarantees). Load address and opcode are taken from ex_* at completion.
- Stray readdatavalid in IDLE/CMD with no load pending is ignored.
- Reset mid-access returns to IDLE. A late response after reset is ignored per the stray-response rule.

Optional Feature:
- Macro: MEM_MISALIGN_EXC_EN.
- Defined:
  - H with a[0]=1, or W with a!=0, is misaligned.
  - No bus command is issued and no stall occurs.
  - Extra outputs wb_exception (1), wb_exception_code (5 bits: load 4, store 6) and wb_mtval (32, =ex_address) register next edge.
  - wb_reg_write is forced to 0.
- Undefined: those ports are absent. Misaligned accesses proceed with the truncated lane rules above.

Test Plan:
- SW addr 0x104 data 0xDEADBEEF, waitrequest=0 -> dbus_write=1, byteenable 1111, address 0x104, mem_stall=0, wb_valid=1 next edge, wb_reg_write=0.
- LB addr 0x203, readdata 0x80xxxxxx, readdatavalid 2 cycles after accept -> mem_stall high 2 cycles, wb_reg_writedata=0xFFFFFF80; LBU same -> 0x00000080.
- SH addr 0x12, data 0x0000ABCD, waitrequest high 3 cycles -> command held 4 cycles, byteenable 1100, writedata 0xABCDABCD, 3 bubbles then wb_valid.
- LH addr 0x40, readdatavalid same cycle as accept, readdata 0x00007FFE -> no stall, wb_reg_writedata=0x00007FFE.
- Reset asserted while in RESP, then readdatavalid -> state IDLE, all wb_*=0, response ignored, next ALU op passes in 1 cycle.
- With MEM_MISALIGN_EXC_EN: LW addr 0x6 -> no dbus_read, wb_exception=1, code 4, wb_mtval=0x6, wb_reg_write=0.
